// File: rtl/keypad_pkg.sv
// Shared key codes, debounce FSM state type and key-class helper for the
// keypad entry path.
package keypad_pkg;

  localparam logic [4:0] KEY_ENTER = 5'd16;
  localparam logic [4:0] KEY_BKSP  = 5'd17;
  localparam logic [4:0] KEY_CLR   = 5'd18;
  localparam logic [4:0] KEY_NEG   = 5'd19;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } kp_state_t;

  // Codes 0-15 are hex digits; everything from 16 up is a function or alias.
  function automatic logic is_digit(input logic [4:0] code);
    return (code[4] == 1'b0);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Turns the keysync activity level into a single strobe per debounced press.
// A press must stay high DEBOUNCE_CYC cycles after its rising edge, and a
// release must stay low DEBOUNCE_CYC cycles, before the next press is seen.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       keyclk,
  input  logic [4:0] keycode,
  output logic       key_stb,
  output logic [4:0] key_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

  kp_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             keyclk_q;

  // Press/hold/release sequencer; keyclk_q resets high so a key held
  // through reset has to be released before it can trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      keyclk_q  <= 1'b1;
      key_stb   <= 1'b0;
      key_code  <= '0;
    end else begin
      keyclk_q <= keyclk;
      key_stb  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (keyclk && !keyclk_q) begin
            key_code  <= keycode;
            cnt_reg   <= CNT_W'(1);
            state_reg <= PRESS;
          end
        end
        PRESS: begin
          if (!keyclk) begin
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_MAX) begin
            key_stb   <= 1'b1;
            state_reg <= HELD;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        HELD: begin
          if (!keyclk) begin
            cnt_reg   <= CNT_W'(1);
            state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          if (keyclk) begin
            state_reg <= HELD;
          end else if (cnt_reg == CNT_MAX) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounced key strobes edit a hex entry buffer,
// and ENTER hands the buffer to the consumer over a valid/ready register.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   keycode,
  input  logic                         keyclk,
  output logic [4*DIGITS-1:0]          disp_o,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         out_valid,
  output logic [4*DIGITS-1:0]          out_data,
  input  logic                         out_ready,
  output logic                         err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DIG_MAX = CW'(DIGITS);

  logic          key_stb;
  logic [4:0]    key_code;

  logic [W-1:0]  entry_reg, entry_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          valid_reg, valid_next;
  logic [W-1:0]  data_reg, data_next;
  logic          err_reg, err_next;

  logic [W-1:0]  entry_shl;
  logic [W-1:0]  entry_shr;

  keypad_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .keyclk  (keyclk),
    .keycode (keycode),
    .key_stb (key_stb),
    .key_code(key_code)
  );

  // Nibble lanes: shift-in of the new digit at the bottom, and backspace
  // shift-out with zero fill at the top.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      if (gi == 0) begin : g_lo
        assign entry_shl[3:0] = key_code[3:0];
      end else begin : g_up
        assign entry_shl[4*gi +: 4] = entry_reg[4*(gi-1) +: 4];
      end
      if (gi == DIGITS - 1) begin : g_top
        assign entry_shr[4*gi +: 4] = 4'h0;
      end else begin : g_mid
        assign entry_shr[4*gi +: 4] = entry_reg[4*(gi+1) +: 4];
      end
    end
  endgenerate

  // Key action decode plus handshake retirement of the pending output.
  always_comb begin
    entry_next = entry_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    err_next   = 1'b0;
    valid_next = valid_reg && !out_ready;
    if (key_stb) begin
      if (is_digit(key_code)) begin
        if (cnt_reg < DIG_MAX) begin
          entry_next = entry_shl;
          cnt_next   = cnt_reg + CW'(1);
        end else begin
          err_next = 1'b1;
        end
      end else begin
        case (key_code)
          KEY_ENTER: begin
            // Only accepted when the output slot is free or being freed now.
            if (!valid_reg || out_ready) begin
              data_next  = entry_reg;
              valid_next = 1'b1;
              entry_next = '0;
              cnt_next   = '0;
            end else begin
              err_next = 1'b1;
            end
          end
          KEY_BKSP: begin
            if (cnt_reg != '0) begin
              entry_next = entry_shr;
              cnt_next   = cnt_reg - CW'(1);
            end
          end
          KEY_CLR: begin
            entry_next = '0;
            cnt_next   = '0;
          end
          KEY_NEG: begin
            // Negation fills the whole word, so the buffer counts as full.
            entry_next = -entry_reg;
            cnt_next   = DIG_MAX;
          end
          default: err_next = 1'b1;
        endcase
      end
    end
  end

  // Entry buffer, digit count, output register and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      entry_reg <= entry_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  assign disp_o    = entry_reg;
  assign digit_cnt = cnt_reg;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl (DIGITS=8, DEBOUNCE_CYC=4).
module tb_keypad_entry_ctrl;

  localparam int DIGITS = 8;
  localparam int DEB    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  keycode;
  logic        keyclk;
  logic [31:0] disp_o;
  logic [3:0]  digit_cnt;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        err;

  always #5 clk = ~clk;

  keypad_entry_ctrl #(.DIGITS(DIGITS), .DEBOUNCE_CYC(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .keycode  (keycode),
    .keyclk   (keyclk),
    .disp_o   (disp_o),
    .digit_cnt(digit_cnt),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .err      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_count = 0;
  int last_errs;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] m_buf, m_data;
  int          m_cnt;
  logic        m_valid, m_err;

  typedef struct {
    logic [4:0]  code;
    int          high;
    logic        ready;
    logic [31:0] disp;
    int          cnt;
    logic        valid;
    logic [31:0] data;
    int          errs;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
    end
  endtask

  // Output monitor: error pulses, stall stability and transfer scoreboard.
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (err) err_count++;
      if (stall_prev) begin
        chk("stall valid", 32'(out_valid), 32'd1);
        chk("stall data", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer: unexpected transfer of 0x%0h", out_data);
        end else begin
          chk("xfer data", out_data, exp_q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  function automatic void model_reset();
    m_buf = 0; m_cnt = 0; m_valid = 0; m_data = 0; m_err = 0;
    exp_q.delete();
  endfunction

  // A press takes effect only if keyclk stays high beyond the debounce window.
  function automatic void model_press(input logic [4:0] code, input int high, input logic ready);
    m_err = 0;
    if (ready) m_valid = 0;
    if (high > DEB) begin
      if (code < 16) begin
        if (m_cnt < DIGITS) begin m_buf = m_buf * 16 + 32'(code); m_cnt++; end
        else m_err = 1;
      end else if (code == 16) begin
        if (!m_valid) begin
          m_data = m_buf; exp_q.push_back(m_buf);
          m_valid = !ready; m_buf = 0; m_cnt = 0;
        end else m_err = 1;
      end else if (code == 17) begin
        if (m_cnt > 0) begin m_buf = m_buf / 16; m_cnt--; end
      end else if (code == 18) begin
        m_buf = 0; m_cnt = 0;
      end else if (code == 19) begin
        m_buf = 32'd0 - m_buf; m_cnt = DIGITS;
      end else begin
        m_err = 1;
      end
    end
  endfunction

  task automatic press(input logic [4:0] code, input int high, input int low, input logic ready);
    int e0;
    e0 = err_count;
    model_press(code, high, ready);
    @(negedge clk);
    keycode = code; out_ready = ready; keyclk = 1'b1;
    repeat (high) @(negedge clk);
    keyclk = 1'b0;
    repeat (low) @(negedge clk);
    #2;
    last_errs = err_count - e0;
  endtask

  task automatic add_vec(input logic [4:0] code, input int high, input logic ready,
                         input logic [31:0] disp, input int cnt, input logic valid,
                         input logic [31:0] data, input int errs);
    vec_t v;
    v.code = code; v.high = high; v.ready = ready; v.disp = disp; v.cnt = cnt;
    v.valid = valid; v.data = data; v.errs = errs;
    vecs.push_back(v);
  endtask

  task automatic chk_state(input string tag, input logic [31:0] d, input int c,
                           input logic v, input logic [31:0] od);
    chk({tag, " disp"}, disp_o, d);
    chk({tag, " cnt"}, 32'(digit_cnt), 32'(c));
    chk({tag, " valid"}, 32'(out_valid), 32'(v));
    chk({tag, " data"}, out_data, od);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    logic [4:0] rc;
    int rh, rl, rsel;
    logic rr;

    rst = 1'b1; keyclk = 1'b0; keycode = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    chk_state("reset", 32'h0, 0, 1'b0, 32'h0);
    chk("reset err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // directed vectors: one press each, state checked after release
    add_vec(5'd1,  8, 1, 32'h1,     1, 0, 32'h0, 0);
    add_vec(5'd2,  8, 1, 32'h12,    2, 0, 32'h0, 0);
    add_vec(5'd10, 8, 1, 32'h12A,   3, 0, 32'h0, 0);
    add_vec(5'd16, 8, 1, 32'h0,     0, 0, 32'h12A, 0);
    add_vec(5'd7,  3, 1, 32'h0,     0, 0, 32'h12A, 0);
    add_vec(5'd7,  1, 1, 32'h0,     0, 0, 32'h12A, 0);
    for (int k = 1; k <= 8; k++)
      add_vec(5'd15, 8, 1, 32'hFFFF_FFFF >> (32 - 4*k), k, 0, 32'h12A, 0);
    add_vec(5'd15, 8, 1, 32'hFFFF_FFFF, 8, 0, 32'h12A, 1);
    add_vec(5'd17, 8, 1, 32'h0FFF_FFFF, 7, 0, 32'h12A, 0);
    add_vec(5'd18, 8, 1, 32'h0,     0, 0, 32'h12A, 0);
    add_vec(5'd17, 8, 1, 32'h0,     0, 0, 32'h12A, 0);
    add_vec(5'd3,  8, 1, 32'h3,     1, 0, 32'h12A, 0);
    add_vec(5'd19, 8, 1, 32'hFFFF_FFFD, 8, 0, 32'h12A, 0);
    add_vec(5'd21, 8, 1, 32'hFFFF_FFFD, 8, 0, 32'h12A, 1);
    add_vec(5'd31, 8, 1, 32'hFFFF_FFFD, 8, 0, 32'h12A, 1);
    add_vec(5'd18, 8, 1, 32'h0,     0, 0, 32'h12A, 0);
    add_vec(5'd5,  8, 0, 32'h5,     1, 0, 32'h12A, 0);
    add_vec(5'd16, 8, 0, 32'h0,     0, 1, 32'h5, 0);
    add_vec(5'd7,  8, 0, 32'h7,     1, 1, 32'h5, 0);
    add_vec(5'd16, 8, 0, 32'h7,     1, 1, 32'h5, 1);

    foreach (vecs[i]) begin
      press(vecs[i].code, vecs[i].high, 8, vecs[i].ready);
      $display("vec %0d: code=%0d high=%0d ready=%0b disp=0x%0h cnt=%0d valid=%0b data=0x%0h errs=%0d",
               i, vecs[i].code, vecs[i].high, vecs[i].ready, disp_o, digit_cnt, out_valid, out_data, last_errs);
      chk_state($sformatf("vec%0d", i), vecs[i].disp, vecs[i].cnt, vecs[i].valid, vecs[i].data);
      chk($sformatf("vec%0d errs", i), 32'(last_errs), 32'(vecs[i].errs));
    end

    // ENTER with out_ready high only on the execute cycle: old 5 leaves, 7 loads
    exp_q.push_back(32'h7);
    m_valid = 1; m_data = 32'h7; m_buf = 0; m_cnt = 0;
    @(negedge clk);
    keycode = 5'd16; keyclk = 1'b1;
    repeat (DEB + 1) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    $display("enter-on-ready: valid=%0b data=0x%0h disp=0x%0h", out_valid, out_data, disp_o);
    chk_state("enter-on-ready", 32'h0, 0, 1'b1, 32'h7);
    keyclk = 1'b0;
    repeat (8) @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    m_valid = 0;
    $display("drain: valid=%0b queue=%0d", out_valid, exp_q.size());
    chk("drain valid", 32'(out_valid), 32'd0);
    chk("drain queue", 32'(exp_q.size()), 32'd0);

    // long hold gives one action only; release bounce does not retrigger
    press(5'd4, 100, 8, 1);
    $display("hold100: disp=0x%0h cnt=%0d", disp_o, digit_cnt);
    chk_state("hold100", 32'h4, 1, 1'b0, 32'h7);
    chk("hold100 errs", 32'(last_errs), 32'd0);
    model_press(5'd2, 8, 1'b1);
    @(negedge clk);
    keycode = 5'd2; keyclk = 1'b1;
    repeat (8) @(negedge clk); keyclk = 1'b0;
    repeat (2) @(negedge clk); keyclk = 1'b1;
    repeat (3) @(negedge clk); keyclk = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    $display("bounce: disp=0x%0h cnt=%0d", disp_o, digit_cnt);
    chk_state("bounce", 32'h42, 2, 1'b0, 32'h7);

    // reset during PRESS with output pending, key held across reset
    press(5'd1, 8, 8, 1);
    press(5'd16, 8, 8, 0);
    press(5'd9, 8, 8, 0);
    chk_state("pre-rst", 32'h9, 1, 1'b1, 32'h421);
    @(negedge clk);
    keycode = 5'd3; keyclk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    $display("rst-in-press: disp=0x%0h cnt=%0d valid=%0b data=0x%0h err=%0b",
             disp_o, digit_cnt, out_valid, out_data, err);
    chk_state("rst-in-press", 32'h0, 0, 1'b0, 32'h0);
    chk("rst-in-press err", 32'(err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    e0 = err_count;
    repeat (20) @(negedge clk);
    #2;
    $display("held-after-rst: disp=0x%0h cnt=%0d", disp_o, digit_cnt);
    chk_state("held-after-rst", 32'h0, 0, 1'b0, 32'h0);
    chk("held-after-rst errs", 32'(err_count - e0), 32'd0);
    @(negedge clk);
    keyclk = 1'b0;
    repeat (8) @(negedge clk);
    press(5'd5, 8, 8, 1);
    $display("retrigger: disp=0x%0h cnt=%0d", disp_o, digit_cnt);
    chk_state("retrigger", 32'h5, 1, 1'b0, 32'h0);

    // randomized presses against the reference model
    for (int i = 0; i < 150; i++) begin
      rsel = $urandom_range(0, 99);
      if (rsel < 70)      rc = 5'($urandom_range(0, 15));
      else if (rsel < 80) rc = 5'd16;
      else if (rsel < 87) rc = 5'd17;
      else if (rsel < 91) rc = 5'd18;
      else if (rsel < 95) rc = 5'd19;
      else                rc = 5'($urandom_range(20, 31));
      rh = ($urandom_range(0, 9) < 2) ? $urandom_range(1, 3) : $urandom_range(5, 12);
      rl = $urandom_range(6, 10);
      rr = ($urandom_range(0, 3) != 0);
      press(rc, rh, rl, rr);
      $display("rnd %0d: code=%0d high=%0d ready=%0b disp=0x%0h cnt=%0d valid=%0b data=0x%0h errs=%0d",
               i, rc, rh, rr, disp_o, digit_cnt, out_valid, out_data, last_errs);
      chk_state($sformatf("rnd%0d", i), m_buf, m_cnt, m_valid, m_data);
      chk($sformatf("rnd%0d errs", i), 32'(last_errs), 32'(m_err));
    end

    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("final valid", 32'(out_valid), 32'd0);
    chk("final queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
